// File: rtl/rv_decode_stage_pkg.sv
// Shared types for the RV32I/RV64I decode stage: format codes, base opcodes, buffered entry.
package rv_dec_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Entries carry the widest immediate so one struct serves both XLEN builds.
    localparam int IMM_MAX_W = 64;

    typedef struct packed {
        logic rs1_used;
        logic rs2_used;
        logic rd_we;
    } flags_t;

    typedef struct packed {
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        flags_t               flags;
        fmt_e                 fmt;
        logic [IMM_MAX_W-1:0] imm;
        logic                 illegal;
    } entry_t;

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface rv_decode_stage_if #(parameter int XLEN = 32);
    import rv_dec_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_we;
    fmt_e            fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;

    modport master (
        output flush, in_valid, inst, out_ready,
        input  in_ready, out_valid, rs1, rs2, rd, rs1_used, rs2_used, rd_we, fmt, imm, illegal
    );

    modport slave (
        input  flush, in_valid, inst, out_ready,
        output in_ready, out_valid, rs1, rs2, rd, rs1_used, rs2_used, rd_we, fmt, imm, illegal
    );
endinterface

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator for the base RISC-V formats, sign-extended to XLEN.
module rv_imm_gen
    import rv_dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;
    logic        unused_opcode;

    assign unused_opcode = ^inst[6:0];

    always_comb begin
        imm32 = 32'd0;
        case (fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'd0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    // Every 32-bit form is already sign-correct, so widening is a plain signed extension.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Decode stage: classify, extract fields, build immediate; output register plus one skid entry.
// Latency 1 cycle when empty; in_ready is !skid_valid, so fetch stalls only once both entries fill.
module rv_decode_stage
    import rv_dec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    rv_decode_stage_if.slave bus,
    output logic [CNT_W-1:0] illegal_cnt
);

    fmt_e            fmt_d;
    logic            ill_d;
    logic            rd_field;
    logic [XLEN-1:0] imm_d;
    entry_t          dec;
    entry_t          out_q;
    entry_t          skid_q;
    logic            out_valid_q;
    logic            skid_valid;
    logic            accept;
    logic            drain;
    logic            unused_imm;

    always_comb begin
        fmt_d = FMT_R;
        ill_d = 1'b0;
        case (bus.inst[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt_d = FMT_I;
            OP_STORE:                            fmt_d = FMT_S;
            OP_BRANCH:                           fmt_d = FMT_B;
            OP_LUI, OP_AUIPC:                    fmt_d = FMT_U;
            OP_JAL:                              fmt_d = FMT_J;
            OP_REG:                              fmt_d = FMT_R;
            default:                             ill_d = 1'b1;
        endcase
    end

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (bus.inst),
        .fmt  (fmt_d),
        .imm  (imm_d)
    );

    // Unrecognised opcodes decode as R with every register field forced off.
    always_comb begin
        dec                = '0;
        rd_field           = !ill_d && (fmt_d inside {FMT_R, FMT_I, FMT_U, FMT_J});
        dec.flags.rs1_used = !ill_d && (fmt_d inside {FMT_R, FMT_I, FMT_S, FMT_B});
        dec.flags.rs2_used = !ill_d && (fmt_d inside {FMT_R, FMT_S, FMT_B});
        dec.flags.rd_we    = rd_field && (bus.inst[11:7] != 5'd0);
        dec.rs1            = dec.flags.rs1_used ? bus.inst[19:15] : 5'd0;
        dec.rs2            = dec.flags.rs2_used ? bus.inst[24:20] : 5'd0;
        dec.rd             = rd_field ? bus.inst[11:7] : 5'd0;
        dec.fmt            = fmt_d;
        dec.imm            = IMM_MAX_W'($signed(imm_d));
        dec.illegal        = ill_d;
    end

    assign accept = bus.in_valid && !skid_valid && !bus.flush;
    assign drain  = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (drain || !out_valid_q) begin
            // A full skid entry always takes priority; in_ready is low then, so nothing is accepted.
            if (skid_valid) begin
                out_q       <= skid_q;
                out_valid_q <= 1'b1;
                skid_valid  <= 1'b0;
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (accept && dec.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = !skid_valid;
    assign bus.out_valid = out_valid_q;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.rd        = out_q.rd;
    assign bus.rs1_used  = out_q.flags.rs1_used;
    assign bus.rs2_used  = out_q.flags.rs2_used;
    assign bus.rd_we     = out_q.flags.rd_we;
    assign bus.fmt       = out_q.fmt;
    assign bus.imm       = out_q.imm[XLEN-1:0];
    assign bus.illegal   = out_q.illegal;
    assign unused_imm    = ^out_q.imm;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench: two stages (XLEN=32/CNT_W=16 and XLEN=64/CNT_W=2) share one random stimulus stream.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst = 32'd0;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    rv_decode_stage_if #(.XLEN(32)) ifa ();
    rv_decode_stage_if #(.XLEN(64)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.flush     = flush;
    assign ifa.out_ready = out_ready;
    assign ifa.inst      = inst;
    assign ifb.in_valid  = in_valid;
    assign ifb.flush     = flush;
    assign ifb.out_ready = out_ready;
    assign ifb.inst      = inst;

    rv_decode_stage #(.XLEN(32), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa), .illegal_cnt(cnt_a));
    rv_decode_stage #(.XLEN(64), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb), .illegal_cnt(cnt_b));

    typedef struct {
        int     rs1, rs2, rd;
        bit     rs1_used, rs2_used, rd_we;
        int     fmt;
        longint imm;
        bit     illegal;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   occ = 0;
    int   exp_cnt = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    function automatic longint sext(longint v, int n);
        if (v >= (longint'(1) << (n - 1))) return v - (longint'(1) << n);
        return v;
    endfunction

    function automatic exp_t model(logic [31:0] i);
        exp_t e;
        bit   rd_used;
        e = '{default: 0};
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: e.fmt = 1;
            7'h23:                      e.fmt = 2;
            7'h63:                      e.fmt = 3;
            7'h37, 7'h17:               e.fmt = 4;
            7'h6F:                      e.fmt = 5;
            7'h33:                      e.fmt = 0;
            default: begin e.fmt = 0; e.illegal = 1; end
        endcase
        e.rs1_used = !e.illegal && (e.fmt <= 3);
        e.rs2_used = !e.illegal && (e.fmt == 0 || e.fmt == 2 || e.fmt == 3);
        rd_used    = !e.illegal && (e.fmt == 0 || e.fmt == 1 || e.fmt == 4 || e.fmt == 5);
        e.rs1      = e.rs1_used ? int'(i[19:15]) : 0;
        e.rs2      = e.rs2_used ? int'(i[24:20]) : 0;
        e.rd       = rd_used ? int'(i[11:7]) : 0;
        e.rd_we    = rd_used && (i[11:7] != 0);
        case (e.fmt)
            1: e.imm = sext(longint'(i[31:20]), 12);
            2: e.imm = sext(longint'({i[31:25], i[11:7]}), 12);
            3: e.imm = sext(longint'({i[31], i[7], i[30:25], i[11:8]}), 12) * 2;
            4: e.imm = sext(longint'(i[31:12]), 20) * 4096;
            5: e.imm = sext(longint'({i[31], i[19:12], i[20], i[30:21]}), 20) * 2;
            default: e.imm = 0;
        endcase
        return e;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drives one cycle of stimulus and records the expected decode of anything the stage accepts.
    task automatic step(bit v, logic [31:0] i, bit f, bit r);
        @(posedge clk);
        #2;
        in_valid  = v;
        inst      = i;
        flush     = f;
        out_ready = r;
        if (v && !f && occ < 2) exp_q.push_back(model(i));
    endtask

    task automatic rand_step();
        logic [31:0] i;
        i = $urandom;
        if ($urandom_range(0, 9) < 8) i[6:0] = ops[$urandom_range(0, 9)];
        step($urandom_range(0, 3) != 0, i, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, " a.out_valid"}, 64'(ifa.out_valid), 64'd0);
        chk({tag, " a.in_ready"},  64'(ifa.in_ready),  64'd1);
        chk({tag, " b.out_valid"}, 64'(ifb.out_valid), 64'd0);
        chk({tag, " b.in_ready"},  64'(ifb.in_ready),  64'd1);
        chk({tag, " a.cnt"},       64'(cnt_a),         64'd0);
        chk({tag, " b.cnt"},       64'(cnt_b),         64'd0);
        chk({tag, " a.imm"},       64'(ifa.imm),       64'd0);
        chk({tag, " b.imm"},       ifb.imm,            64'd0);
        chk({tag, " a.rd/rs1"},    64'({ifa.rd, ifa.rs1, ifa.rs2}), 64'd0);
        chk({tag, " b.fmt"},       64'(ifb.fmt),       64'd0);
    endtask

    // Monitor: compares the presented entry with the scoreboard head, then retires it on transfer.
    initial begin
        bit xfer, acc;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                chk("a.out_valid", 64'(ifa.out_valid), 64'(occ > 0));
                chk("b.out_valid", 64'(ifb.out_valid), 64'(occ > 0));
                chk("a.in_ready",  64'(ifa.in_ready),  64'(occ < 2));
                chk("b.in_ready",  64'(ifb.in_ready),  64'(occ < 2));
                chk("a.illegal_cnt", 64'(cnt_a), 64'((exp_cnt > 65535) ? 65535 : exp_cnt));
                chk("b.illegal_cnt", 64'(cnt_b), 64'((exp_cnt > 3) ? 3 : exp_cnt));
                if (occ > 0) begin
                    mon_e = exp_q[0];
                    chk("a.regs",  64'({ifa.rs1, ifa.rs2, ifa.rd}), 64'({5'(mon_e.rs1), 5'(mon_e.rs2), 5'(mon_e.rd)}));
                    chk("b.regs",  64'({ifb.rs1, ifb.rs2, ifb.rd}), 64'({5'(mon_e.rs1), 5'(mon_e.rs2), 5'(mon_e.rd)}));
                    chk("a.flags", 64'({ifa.rs1_used, ifa.rs2_used, ifa.rd_we, ifa.illegal}),
                        64'({mon_e.rs1_used, mon_e.rs2_used, mon_e.rd_we, mon_e.illegal}));
                    chk("b.flags", 64'({ifb.rs1_used, ifb.rs2_used, ifb.rd_we, ifb.illegal}),
                        64'({mon_e.rs1_used, mon_e.rs2_used, mon_e.rd_we, mon_e.illegal}));
                    chk("a.fmt", 64'(ifa.fmt), 64'(mon_e.fmt));
                    chk("b.fmt", 64'(ifb.fmt), 64'(mon_e.fmt));
                    chk("a.imm", 64'(ifa.imm), 64'(mon_e.imm[31:0]));
                    chk("b.imm", ifb.imm, 64'(mon_e.imm));
                end
                xfer = (occ > 0) && out_ready;
                acc  = in_valid && !flush && (occ < 2);
                if (flush) begin
                    exp_q.delete();
                    occ = 0;
                end else begin
                    if (xfer) begin
                        void'(exp_q.pop_front());
                        occ--;
                    end
                    if (acc) begin
                        occ++;
                        if (exp_q[$].illegal) exp_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #3;
        check_reset_values("reset");
        rst = 1'b0;

        // addi x1,x2,-1 into an empty stage: visible the cycle after acceptance.
        step(1, 32'hFFF10093, 0, 1);
        step(0, 32'd0, 0, 1);
        #1;
        chk("addi a.imm", 64'(ifa.imm), 64'h0000_0000_FFFF_FFFF);
        chk("addi b.imm", ifb.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi a.rd_we/rd/rs1", 64'({ifa.rd_we, ifa.rd, ifa.rs1}), 64'({1'b1, 5'd1, 5'd2}));

        step(1, 32'h00512423, 0, 1);
        step(1, 32'hFE000EE3, 0, 1);
        step(1, 32'h123451B7, 0, 1);
        repeat (2) step(0, 32'd0, 0, 1);

        // Three back-to-back offers with downstream stalled: the third waits at the input.
        step(1, 32'h00100093, 0, 0);
        step(1, 32'h00200113, 0, 0);
        step(1, 32'h00300193, 0, 0);
        #1;
        chk("bp a.in_ready", 64'(ifa.in_ready), 64'd0);
        step(1, 32'h00300193, 0, 1);
        step(1, 32'h00300193, 0, 1);
        repeat (4) step(0, 32'd0, 0, 1);

        repeat (2) step(1, 32'h0000007F, 0, 1);
        step(0, 32'd0, 0, 1);
        #1;
        chk("two illegal a.cnt", 64'(cnt_a), 64'd2);

        // Flush with both entries full, while an illegal word is offered and must not count.
        step(1, 32'hFFF10093, 0, 0);
        step(1, 32'h00512423, 0, 0);
        step(1, 32'h0000007F, 1, 0);
        step(0, 32'd0, 0, 0);
        #1;
        chk("flush a.out_valid", 64'(ifa.out_valid), 64'd0);
        chk("flush a.in_ready",  64'(ifa.in_ready),  64'd1);
        chk("flush a.cnt",       64'(cnt_a),         64'd2);

        repeat (5) step(1, 32'h0000007F, 0, 1);
        repeat (3) step(0, 32'd0, 0, 1);
        #1;
        chk("sat b.cnt", 64'(cnt_b), 64'd3);
        chk("sat a.cnt", 64'(cnt_a), 64'd7);

        repeat (1500) rand_step();

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        #1;
        check_reset_values("async rst");
        exp_q.delete();
        occ     = 0;
        exp_cnt = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;

        repeat (1500) rand_step();
        repeat (4) step(0, 32'd0, 0, 1);
        #1;
        chk("final a.out_valid", 64'(ifa.out_valid), 64'd0);
        chk("final b.out_valid", 64'(ifb.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Pipelined RV32I/RV64I instruction-field decode and immediate-generation stage with a valid/ready handshake on both sides. It sits between instruction fetch and the register file / execute stage. It extracts register addresses, classifies the instruction format and produces a sign-extended immediate for all base formats (R, I, S, B, U, J). A two-entry skid buffer decouples downstream stalls from the fetch side.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values are 32 and 64. The immediate is sign-extended to XLEN.
- CNT_W, 16: width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- inst  in  32  instruction word.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  downstream accepts.
- rs1, rs2, rd  out  5 each  register addresses.
- rs1_used, rs2_used, rd_we  out  1 each  operand-use and write-enable flags.
- fmt  out  3  format code from rv_dec_pkg.
- imm  out  XLEN  sign-extended immediate.
- illegal  out  1  opcode not recognised.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Opcode (inst[6:0]) classification:
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → R.
  - Any other opcode → fmt R, illegal=1, rs1_used=rs2_used=rd_we=0.
- Register fields:
  - rs1 = inst[19:15] for R/I/S/B, else 0.
  - rs2 = inst[24:20] for R/S/B, else 0.
  - rd = inst[11:7] for R/I/U/J, else 0.
  - Each `_used`/`rd_we` flag is 1 exactly when the corresponding field is non-forced. rd_we is additionally 0 when rd=0.
- Immediates, all sign-extended from inst[31] to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R: 0.
- Buffering: an output register (out_valid) plus a skid register (skid_valid).
  - Input is accepted when in_valid && in_ready && !flush.
  - An accepted entry goes to the output register if the output register is empty or being drained this cycle; otherwise it goes to the skid register.
  - When the output register drains and the skid register is full, the skid entry moves to the output register.
  - Order is always preserved; no entry is ever dropped or duplicated.
- illegal_cnt increments on each accepted illegal instruction and saturates at all-ones.

## Timing
- Reset values: out_valid=0, skid_valid=0, in_ready=1, illegal_cnt=0. All data outputs are 0.
- Reset asserted mid-transfer discards both entries immediately.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (valid in cycle N+1) when the stage is empty.
- Throughput: 1 per cycle while out_ready=1.
- Output data is held stable while out_valid && !out_ready.
- in_ready deasserts the cycle after the skid register fills. It reasserts the cycle after the skid register drains.
- Simultaneous accept and drain with the skid register full: the skid entry moves to the output register. in_ready is 0 in that cycle, so no accept can occur.
- Flush has priority over everything except reset:
  - The next edge clears out_valid and skid_valid.
  - An input offered in the flush cycle is not accepted and is not counted.
  - illegal_cnt is not cleared by flush.

## Structure
- Package rv_dec_pkg holds:
  - the fmt enum: R=0, I=1, S=2, B=3, U=4, J=5;
  - opcode localparams;
  - an entry struct {rs1, rs2, rd, flags, fmt, imm, illegal}.
- Sub-module rv_imm_gen (combinational): inst and fmt in, XLEN-wide imm out. Instantiated once, before the buffer registers.
- The top level contains only classification, the two entry registers, handshake logic and the counter.

## Test plan
- Basic I-type: addi x1,x2,-1 (0xFFF10093) with out_ready=1 → next cycle:
  - fmt=I, rs1=2, rs2=0, rd=1, rd_we=1, imm=0xFFFFFFFF.
  - With XLEN=64: imm=0xFFFFFFFFFFFFFFFF.
- S-type: sw x5,8(x2) (0x00512423) → fmt=S, rs1=2, rs2=5, rd=0, rd_we=0, imm=8.
- B-type and U-type:
  - beq x0,x0,-4 (0xFE000EE3) → fmt=B, imm=0xFFFFFFFC.
  - lui x3,0x12345 (0x123451B7) → fmt=U, rs1_used=0, rd=3, imm=0x12345000.
- Backpressure:
  - Offer 3 back-to-back instructions with out_ready=0 → in_ready drops after the 2nd is accepted; the 3rd is held at the input.
  - Raise out_ready → all 3 emerge in order, one per cycle, none lost.
- Illegal and flush:
  - Offer 0x0000007F twice → illegal=1 on both; illegal_cnt=2.
  - Assert flush while two entries are buffered → out_valid=0, in_ready=1 next cycle; illegal_cnt is still 2.
- Counter saturation and reset:
  - With CNT_W=2, feed 5 illegal instructions → illegal_cnt stays at 3.
  - Assert rst asynchronously mid-stream → all outputs return to their reset values without waiting for a clock edge.
